// File: rtl/fm_write_sequencer.sv
// ============================================================================
// Module   : fm_write_sequencer
// Purpose  : Sequences a layer's writeback into the float16 feature-map RAM
//            (optional zero-fill, para-write tile bursts, done pulse) and
//            arbitrates the RAM read port for the layer reader.
// Option   : FM_SEQ_READ_IN_WAIT_EN - also grant reads while waiting for a tile
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fm_write_sequencer #(
    parameter int ADDR_W      = 10,
    parameter int SIZE_W      = 6,
    parameter int PARA_Y      = 3,
    parameter int PARA_KERNEL = 2,
    parameter int DATA_W      = 16
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [SIZE_W-1:0]                    cfg_size,
    input  logic [1:0]                           cfg_pad,
    input  logic                                 cfg_add,
    input  logic                                 cfg_zero,
    input  logic [ADDR_W-1:0]                    cfg_tiles,
    input  logic                                 tile_valid,
    input  logic [PARA_Y*PARA_KERNEL*DATA_W-1:0] tile_data,
    output logic                                 tile_ready,
    input  logic                                 ram_write_ready,
    output logic                                 ram_ena_zero_w,
    output logic                                 ram_ena_para_w,
    output logic                                 ram_ena_add_write,
    output logic                                 ram_ena_w,
    output logic [ADDR_W-1:0]                    ram_zero_start_addr,
    output logic [ADDR_W-1:0]                    ram_zero_end_addr,
    output logic [ADDR_W-1:0]                    ram_addr_para_write,
    output logic [SIZE_W-1:0]                    ram_fm_out_size,
    output logic [PARA_Y*PARA_KERNEL*DATA_W-1:0] ram_para_din,
    input  logic                                 rd_req,
    input  logic [1:0]                           rd_type,
    input  logic [ADDR_W-1:0]                    rd_addr,
    input  logic [ADDR_W-1:0]                    rd_sub_addr,
    output logic                                 rd_gnt,
    output logic                                 ram_ena_r,
    output logic [1:0]                           ram_read_type,
    output logic [ADDR_W-1:0]                    ram_addr_read,
    output logic [ADDR_W-1:0]                    ram_sub_addr_read,
    output logic                                 busy,
    output logic                                 done
);

    localparam int SQ_W = 2 * SIZE_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ZERO      = 3'd1,
        S_WAIT_TILE = 3'd2,
        S_WRITE     = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SIZE_W-1:0] size_r;
    logic [1:0]        pad_r;
    logic              add_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] tiles_left_r;
    logic [SIZE_W-1:0] col_r;
    logic [PARA_Y*PARA_KERNEL*DATA_W-1:0] din_r;

    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] row_step;
    logic [SIZE_W-1:0] col_last;
    logic [SQ_W-1:0]   size_sq;
    logic              last_tile;
    logic              tile_take;
    logic              write_done;
    logic              wait_rd;

    // First interior pixel of the padded map: row p, column p.
    assign start_addr = ADDR_W'(cfg_pad) * ADDR_W'(cfg_size) + ADDR_W'(cfg_pad);
    // From the last interior column of a row group to the first of the next one.
    assign row_step   = ADDR_W'(PARA_Y - 1) * ADDR_W'(size_r) + ADDR_W'({pad_r, 1'b1});
    assign col_last   = size_r - SIZE_W'({pad_r, 1'b1});
    assign size_sq    = SQ_W'(size_r) * SQ_W'(size_r);
    assign last_tile  = (tiles_left_r <= ADDR_W'(1));
    assign tile_take  = (state == S_WAIT_TILE) && tile_valid;
    assign write_done = (state == S_WRITE) && ram_write_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = cfg_zero ? S_ZERO : S_WAIT_TILE;
                end
            end
            S_ZERO: begin
                if (ram_write_ready) begin
                    state_nxt = S_WAIT_TILE;
                end
            end
            S_WAIT_TILE: begin
                if (tile_valid) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                if (ram_write_ready) begin
                    state_nxt = last_tile ? S_DONE : S_WAIT_TILE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_r       <= '0;
            pad_r        <= '0;
            add_r        <= 1'b0;
            addr_r       <= '0;
            tiles_left_r <= '0;
            col_r        <= '0;
            din_r        <= '0;
        end else begin
            if ((state == S_IDLE) && start) begin
                size_r       <= cfg_size;
                pad_r        <= cfg_pad;
                add_r        <= cfg_add;
                addr_r       <= start_addr;
                tiles_left_r <= cfg_tiles;
                col_r        <= '0;
            end
            if (tile_take) begin
                din_r <= tile_data;
            end
            if (write_done) begin
                tiles_left_r <= tiles_left_r - 1'b1;
                if (col_r == col_last) begin
                    col_r  <= '0;
                    addr_r <= addr_r + row_step;
                end else begin
                    col_r  <= col_r + 1'b1;
                    addr_r <= addr_r + 1'b1;
                end
            end
        end
    end

    // Read port: a grant is forwarded to the RAM with one cycle of latency.
`ifdef FM_SEQ_READ_IN_WAIT_EN
    assign wait_rd = (state == S_WAIT_TILE) && !tile_valid;
`else
    assign wait_rd = 1'b0;
`endif

    assign rd_gnt = rd_req &&
                    ((((state == S_IDLE) || (state == S_DONE)) && !start) || wait_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_ena_r         <= 1'b0;
            ram_read_type     <= '0;
            ram_addr_read     <= '0;
            ram_sub_addr_read <= '0;
        end else begin
            ram_ena_r <= rd_gnt;
            if (rd_gnt) begin
                ram_read_type     <= rd_type;
                ram_addr_read     <= rd_addr;
                ram_sub_addr_read <= rd_sub_addr;
            end
        end
    end

    assign tile_ready          = (state == S_WAIT_TILE);
    assign ram_ena_zero_w      = (state == S_ZERO);
    assign ram_ena_para_w      = (state == S_WRITE);
    assign ram_ena_add_write   = (state == S_WRITE) && add_r;
    assign ram_ena_w           = 1'b0;
    assign ram_zero_start_addr = '0;
    assign ram_zero_end_addr   = (state == S_ZERO) ? ADDR_W'(size_sq - 1'b1) : '0;
    assign ram_addr_para_write = addr_r;
    assign ram_fm_out_size     = size_r;
    assign ram_para_din        = din_r;
    assign busy                = (state != S_IDLE);
    assign done                = (state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fm_write_sequencer.sv
// ============================================================================
// Module   : tb_fm_write_sequencer
// Purpose  : Self-checking bench for fm_write_sequencer: table of layer
//            configurations plus hand-written read and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fm_write_sequencer;

    localparam int ADDR_W      = 10;
    localparam int SIZE_W      = 6;
    localparam int PARA_Y      = 3;
    localparam int PARA_KERNEL = 2;
    localparam int DATA_W      = 16;
    localparam int TD_W        = PARA_Y * PARA_KERNEL * DATA_W;

`ifdef FM_SEQ_READ_IN_WAIT_EN
    localparam bit READ_IN_WAIT = 1'b1;
`else
    localparam bit READ_IN_WAIT = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [SIZE_W-1:0] cfg_size = '0;
    logic [1:0]        cfg_pad = '0;
    logic              cfg_add = 1'b0;
    logic              cfg_zero = 1'b0;
    logic [ADDR_W-1:0] cfg_tiles = '0;
    logic              tile_valid = 1'b0;
    logic [TD_W-1:0]   tile_data = '0;
    logic              ram_write_ready = 1'b0;
    logic              rd_req = 1'b0;
    logic [1:0]        rd_type = '0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [ADDR_W-1:0] rd_sub_addr = '0;

    logic              tile_ready;
    logic              ram_ena_zero_w, ram_ena_para_w, ram_ena_add_write, ram_ena_w;
    logic [ADDR_W-1:0] ram_zero_start_addr, ram_zero_end_addr, ram_addr_para_write;
    logic [SIZE_W-1:0] ram_fm_out_size;
    logic [TD_W-1:0]   ram_para_din;
    logic              rd_gnt, ram_ena_r;
    logic [1:0]        ram_read_type;
    logic [ADDR_W-1:0] ram_addr_read, ram_sub_addr_read;
    logic              busy, done;

    fm_write_sequencer #(
        .ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .PARA_Y(PARA_Y),
        .PARA_KERNEL(PARA_KERNEL), .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_size(cfg_size), .cfg_pad(cfg_pad), .cfg_add(cfg_add),
        .cfg_zero(cfg_zero), .cfg_tiles(cfg_tiles),
        .tile_valid(tile_valid), .tile_data(tile_data), .tile_ready(tile_ready),
        .ram_write_ready(ram_write_ready),
        .ram_ena_zero_w(ram_ena_zero_w), .ram_ena_para_w(ram_ena_para_w),
        .ram_ena_add_write(ram_ena_add_write), .ram_ena_w(ram_ena_w),
        .ram_zero_start_addr(ram_zero_start_addr), .ram_zero_end_addr(ram_zero_end_addr),
        .ram_addr_para_write(ram_addr_para_write), .ram_fm_out_size(ram_fm_out_size),
        .ram_para_din(ram_para_din),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_sub_addr(rd_sub_addr),
        .rd_gnt(rd_gnt), .ram_ena_r(ram_ena_r), .ram_read_type(ram_read_type),
        .ram_addr_read(ram_addr_read), .ram_sub_addr_read(ram_sub_addr_read),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int size;
        int pad;
        bit add;
        bit zero;
        int tiles;
        int delay;
        int zend;
        bit fixed;
    } layer_t;

    layer_t tbl[6];

    int checks = 0;
    int errors = 0;

    logic [TD_W-1:0]   data_q[$];
    logic [ADDR_W-1:0] addr_q[$];

    bit                exp_r_ena = 1'b0;
    logic [1:0]        exp_r_type = '0;
    logic [ADDR_W-1:0] exp_r_addr = '0;
    logic [ADDR_W-1:0] exp_r_sub = '0;

    task automatic check(input bit ok, input string name,
                         input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
        end
    endtask

    // Raster address of tile t: interior starts at (p,p); row groups are PARA_Y rows tall.
    function automatic logic [ADDR_W-1:0] model_addr(input int s, input int p, input int t);
        int w;
        int a;
        w = s - 2 * p;
        a = (p + (t / w) * PARA_Y) * s + p + (t % w);
        return ADDR_W'(a);
    endfunction

    task automatic read_check();
        check(ram_ena_r == exp_r_ena, "ram_ena_r", ram_ena_r, exp_r_ena);
        if (exp_r_ena) begin
            check(ram_read_type == exp_r_type, "ram_read_type", ram_read_type, exp_r_type);
            check(ram_addr_read == exp_r_addr, "ram_addr_read", ram_addr_read, exp_r_addr);
            check(ram_sub_addr_read == exp_r_sub, "ram_sub_addr_read", ram_sub_addr_read, exp_r_sub);
        end
    endtask

    task automatic drive_read(input bit window, input bit off);
        bit exp_g;
        rd_req      = off ? 1'b0 : ($urandom_range(0, 1) == 1);
        rd_type     = 2'($urandom_range(0, 2));
        rd_addr     = ADDR_W'($urandom);
        rd_sub_addr = ADDR_W'($urandom);
        #1;
        exp_g = rd_req && window;
        check(rd_gnt == exp_g, "rd_gnt", rd_gnt, exp_g);
        exp_r_ena  = exp_g;
        exp_r_type = rd_type;
        exp_r_addr = rd_addr;
        exp_r_sub  = rd_sub_addr;
    endtask

    task automatic run_layer(input int idx);
        layer_t            L;
        int                zcnt, hold, sent, written, done_cnt, cyc;
        bit                fin, window, off;
        logic [TD_W-1:0]   cur_d;
        logic [ADDR_W-1:0] cur_a;
        L = tbl[idx];
        zcnt = 0; hold = 0; sent = 0; written = 0; done_cnt = 0; cyc = 0; fin = 1'b0;
        cur_d = '0; cur_a = '0;
        @(negedge clk);
        read_check();
        cfg_size        = SIZE_W'(L.size);
        cfg_pad         = 2'(L.pad);
        cfg_add         = L.add;
        cfg_zero        = L.zero;
        cfg_tiles       = ADDR_W'(L.tiles);
        start           = 1'b1;
        tile_valid      = 1'b0;
        ram_write_ready = 1'b0;
        rd_req          = 1'b1;
        rd_type         = 2'd1;
        rd_addr         = ADDR_W'(9);
        #1;
        check(rd_gnt == 1'b0, "start_beats_read", rd_gnt, 1'b0);
        exp_r_ena = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            read_check();
            check(ram_ena_w == 1'b0, "ram_ena_w", ram_ena_w, 1'b0);
            check(!(ram_ena_zero_w && ram_ena_para_w), "one_write_ena",
                  {ram_ena_zero_w, ram_ena_para_w}, 2'b00);
            start = 1'b0;
            tile_valid = 1'b0;
            ram_write_ready = 1'b0;
            off = 1'b0;
            if (done) begin
                done_cnt++;
                check(busy == 1'b1, "busy_in_done", busy, 1'b1);
            end
            if (!busy) begin
                fin = 1'b1;
                off = 1'b1;
            end else if (ram_ena_zero_w) begin
                zcnt++;
                check(ram_zero_start_addr == '0, "zero_start", ram_zero_start_addr, 0);
                check(ram_zero_end_addr == ADDR_W'(L.zend), "zero_end", ram_zero_end_addr, L.zend);
                check(tile_ready == 1'b0, "tile_ready_in_zero", tile_ready, 1'b0);
                if (zcnt == L.delay + 1) ram_write_ready = 1'b1;
            end else if (ram_ena_para_w) begin
                if (hold == 0) begin
                    check(addr_q.size() != 0, "para_without_tile", addr_q.size(), 1);
                    if (addr_q.size() != 0) begin
                        cur_a = addr_q.pop_front();
                        cur_d = data_q.pop_front();
                    end
                end
                check(ram_addr_para_write == cur_a, "para_addr", ram_addr_para_write, cur_a);
                check(ram_para_din == cur_d, "para_din", ram_para_din, cur_d);
                check(ram_ena_add_write == L.add, "ena_add_write", ram_ena_add_write, L.add);
                check(ram_fm_out_size == SIZE_W'(L.size), "fm_out_size", ram_fm_out_size, L.size);
                check(tile_ready == 1'b0, "tile_ready_in_write", tile_ready, 1'b0);
                hold++;
                if (hold == L.delay + 1) begin
                    ram_write_ready = 1'b1;
                    hold = 0;
                    written++;
                end
            end else if (tile_ready) begin
                // write_ready here must be ignored by the sequencer
                ram_write_ready = ($urandom_range(0, 1) == 1);
                if (sent < L.tiles && $urandom_range(0, 3) != 0) begin
                    tile_valid = 1'b1;
                    tile_data  = L.fixed ? 96'h3c00_4000_3c00_3c00_4000_4200
                                         : {$urandom, $urandom, $urandom};
                    data_q.push_back(tile_data);
                    addr_q.push_back(model_addr(L.size, L.pad, sent));
                    sent++;
                end else if ($urandom_range(0, 2) == 0) begin
                    start = 1'b1;
                    off = 1'b1;
                end
            end
            window = !busy || done || (READ_IN_WAIT && tile_ready && !tile_valid);
            drive_read(window, off);
        end
        start = 1'b0;
        check(fin, "layer_timeout", fin, 1'b1);
        check(done_cnt == 1, "done_pulses", done_cnt, 1);
        check(written == L.tiles, "tiles_written", written, L.tiles);
        check(zcnt == (L.zero ? L.delay + 1 : 0), "zero_cycles", zcnt, L.zero ? L.delay + 1 : 0);
        check(addr_q.size() == 0, "tiles_left_over", addr_q.size(), 0);
    endtask

    task automatic reset_mid_write();
        logic all_out;
        @(negedge clk);
        cfg_size = SIZE_W'(8); cfg_pad = 2'd1; cfg_add = 1'b1; cfg_zero = 1'b0;
        cfg_tiles = ADDR_W'(3); start = 1'b1; rd_req = 1'b0;
        @(negedge clk);
        start = 1'b0;
        check(tile_ready == 1'b1, "rst_seq_tile_ready", tile_ready, 1'b1);
        tile_valid = 1'b1;
        tile_data  = {$urandom, $urandom, $urandom};
        @(negedge clk);
        tile_valid = 1'b0;
        check(ram_ena_para_w == 1'b1, "rst_seq_in_write", ram_ena_para_w, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        all_out = |{tile_ready, ram_ena_zero_w, ram_ena_para_w, ram_ena_add_write, ram_ena_w,
                    ram_zero_start_addr, ram_zero_end_addr, ram_addr_para_write,
                    ram_fm_out_size, ram_para_din, rd_gnt, ram_ena_r, ram_read_type,
                    ram_addr_read, ram_sub_addr_read, busy, done};
        check(all_out == 1'b0, "async_reset_outputs", all_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_r_ena = 1'b0;
    endtask

    initial begin
        logic all_out;
        tbl[0] = '{size: 8,  pad: 1, add: 1'b1, zero: 1'b1, tiles: 1, delay: 3, zend: 63,  fixed: 1'b0};
        tbl[1] = '{size: 8,  pad: 1, add: 1'b1, zero: 1'b0, tiles: 1, delay: 5, zend: 63,  fixed: 1'b1};
        tbl[2] = '{size: 8,  pad: 1, add: 1'b1, zero: 1'b0, tiles: 7, delay: 1, zend: 63,  fixed: 1'b0};
        tbl[3] = '{size: 6,  pad: 0, add: 1'b0, zero: 1'b0, tiles: 2, delay: 0, zend: 35,  fixed: 1'b0};
        tbl[4] = '{size: 40, pad: 2, add: 1'b1, zero: 1'b1, tiles: 3, delay: 2, zend: 575, fixed: 1'b0};
        tbl[5] = '{size: 5,  pad: 2, add: 1'b0, zero: 1'b1, tiles: 3, delay: 1, zend: 24,  fixed: 1'b0};

        #12;
        all_out = |{tile_ready, ram_ena_zero_w, ram_ena_para_w, ram_ena_add_write, ram_ena_w,
                    ram_zero_start_addr, ram_zero_end_addr, ram_addr_para_write,
                    ram_fm_out_size, ram_para_din, rd_gnt, ram_ena_r, ram_read_type,
                    ram_addr_read, ram_sub_addr_read, busy, done};
        check(all_out == 1'b0, "reset_outputs", all_out, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle read: granted at once, RAM read strobe one cycle later.
        @(negedge clk);
        rd_req = 1'b1; rd_type = 2'd1; rd_addr = ADDR_W'(9); rd_sub_addr = ADDR_W'(4);
        #1;
        check(rd_gnt == 1'b1, "idle_rd_gnt", rd_gnt, 1'b1);
        @(negedge clk);
        check(ram_ena_r == 1'b1, "idle_ram_ena_r", ram_ena_r, 1'b1);
        check(ram_read_type == 2'd1, "idle_read_type", ram_read_type, 1);
        check(ram_addr_read == ADDR_W'(9), "idle_addr_read", ram_addr_read, 9);
        check(ram_sub_addr_read == ADDR_W'(4), "idle_sub_addr", ram_sub_addr_read, 4);
        rd_req = 1'b0;
        @(negedge clk);
        check(ram_ena_r == 1'b0, "idle_ram_ena_r_drop", ram_ena_r, 1'b0);
        exp_r_ena = 1'b0;

        for (int i = 0; i < 3; i++) run_layer(i);
        reset_mid_write();
        for (int i = 3; i < 6; i++) run_layer(i);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/fm_write_sequencer.md
Name: fm_write_sequencer

Overview:
- Controller in front of the float16 feature-map RAM. It sequences one layer's output writeback into that RAM.
- Writeback order: optional zero-fill of the padded map, then PE-array tiles issued as para-write bursts using the RAM's write_ready handshake, then done.
- Also arbitrates the RAM read port between the layer reader and write traffic.
- Sits between the PE array / layer control FSM and the feature-map RAM.

Parameters:
- ADDR_W, 10, RAM write/read address width (matches WRITE_ADDR_WIDTH/READ_ADDR_WIDTH).
- SIZE_W, 6, fm size width (matches FM_SIZE_WIDTH).
- PARA_Y, 3, output rows per tile.
- PARA_KERNEL, 2, kernels per tile.
- DATA_W, 16, float16 word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a layer.
- cfg_size  in  SIZE_W  padded output map side S (= out_w + 2*cfg_pad).
- cfg_pad  in  2  padding p.
- cfg_add  in  1  1: conv accumulate (ena_add_write=1); 0: fc write.
- cfg_zero  in  1  1: zero-fill before the first tile.
- cfg_tiles  in  ADDR_W  number of tiles in the layer (>=1).
- tile_valid  in  1  PE tile available.
- tile_data  in  PARA_Y*PARA_KERNEL*DATA_W  tile payload.
- tile_ready  out  1  tile accepted this cycle.
- ram_write_ready  in  1  RAM op complete.
- ram_ena_zero_w, ram_ena_para_w, ram_ena_add_write, ram_ena_w  out  1 each  RAM controls; ram_ena_w is always 0.
- ram_zero_start_addr, ram_zero_end_addr, ram_addr_para_write  out  ADDR_W each.
- ram_fm_out_size  out  SIZE_W.
- ram_para_din  out  PARA_Y*PARA_KERNEL*DATA_W.
- rd_req  in  1  reader request.
- rd_type  in  2  0 conv, 1 pool, 2 fc.
- rd_addr, rd_sub_addr  in  ADDR_W each.
- rd_gnt  out  1  read forwarded this cycle.
- ram_ena_r  out  1.
- ram_read_type  out  2.
- ram_addr_read, ram_sub_addr_read  out  ADDR_W each.
- busy  out  1.
- done  out  1  one-cycle pulse at layer end.

Behaviour:
- Reset: every output is 0; state = IDLE.
- States: IDLE, ZERO, WAIT_TILE, WRITE, DONE.
- IDLE:
  - start -> latch cfg.
  - addr := p*S + p, col := 0, tiles_left := cfg_tiles.
  - Next state is ZERO if cfg_zero, else WAIT_TILE.
  - start while not IDLE is ignored.
- ZERO:
  - ram_ena_zero_w = 1, zero_start = 0, zero_end = S*S-1 (ADDR_W truncation).
  - Held until ram_write_ready = 1 is sampled; ena drops next cycle; go to WAIT_TILE.
- WAIT_TILE:
  - tile_ready = 1.
  - On tile_valid & tile_ready, register tile_data into ram_para_din, go to WRITE.
- WRITE:
  - ram_ena_para_w = 1 with stable addr, data, ram_fm_out_size = S, ram_ena_add_write = cfg_add.
  - ram_write_ready sampled 1 -> ena drops next cycle, tiles_left--.
  - Address advance per completed tile:
    - If col == S-2p-1: col := 0, addr += (PARA_Y-1)*S + 2p + 1.
    - Otherwise: col++, addr++.
  - Next state is DONE if tiles_left hits 0, else WAIT_TILE.
- DONE: done = 1 for one cycle, then IDLE.
- busy = 1 in every state except IDLE.
- Only one of ena_zero_w/ena_para_w is ever high.
- ram_write_ready outside ZERO/WRITE is ignored.
- Reads:
  - rd_gnt = rd_req when state is IDLE or DONE (and no start in the same cycle).
  - On grant, ram_ena_r/read_type/addr_read/sub_addr_read are registered; one-cycle latency.
  - Otherwise ram_ena_r = 0.
  - start and rd_req together -> start wins, rd_gnt = 0.
- Reset mid-operation: all RAM enables clear immediately (asynchronous); the in-flight tile is lost.

Optional Feature:
- Macro: FM_SEQ_READ_IN_WAIT_EN.
- Defined: reads are also granted in WAIT_TILE when tile_valid = 0 (no RAM write active). In WAIT_TILE with tile_valid = 1, the tile wins.
- Undefined: reads are granted only in IDLE/DONE.

Test Plan:
- Zero fill: S=8, p=1, cfg_zero=1, tiles=1, write_ready after 3 cycles -> ena_zero_w high 0..63 until ready; then para write at addr 9 with ena_add_write=1; done pulse once.
- Handshake hold: tile {3c00,4000,3c00,3c00,4000,4200}, write_ready delayed 5 cycles -> ena_para_w and din stable all 5 cycles; tile_ready = 0 during WRITE.
- Row wrap: S=8, p=1, PARA_Y=3, tiles=7 -> addresses 9..14, then 9+5+(2*8+3)=33.
- FC mode: cfg_add=0, S=6, p=0, tiles=2 -> addresses 0,1; ena_add_write=0.
- Read arbitration: rd_req type 1 addr 9 while IDLE -> rd_gnt, ram_ena_r next cycle. Same request while WRITE -> no grant. start+rd_req together -> start taken.
- Async reset asserted during WRITE -> all outputs 0 without a clock edge; subsequent start runs normally.
